// File: rtl/a2d_lms_pkg.sv
// Shared types and constants for the LMS step-size scheduler.
// Contents:
//   state_e - scheduler state, encoded IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3
//   E_W     - width of the signed error sample from the adaptive FIR
//   MU_W    - width of the shift-based step size fed back to the FIR
package a2d_lms_pkg;

  localparam int unsigned E_W  = 33;
  localparam int unsigned MU_W = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StTrack   = 2'd2,
    StHold    = 2'd3
  } state_e;

endpackage

// File: rtl/err_window_avg.sv
// Windowed mean of |e| over 2^WIN_LOG2 valid error samples.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   clear      - holds the counter and accumulator at zero and drops any partial window
//   e_in       - signed error sample, e_valid qualifies it
//   avg_out    - truncated mean of the last completed window
//   win_done   - one-cycle pulse when avg_out loads
module err_window_avg
  import a2d_lms_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic signed [E_W-1:0] e_in,
  input  logic                  e_valid,
  output logic [31:0]           avg_out,
  output logic                  win_done
);

  localparam int unsigned AccW = 32 + WIN_LOG2;

  logic [E_W-1:0]      e_neg;
  logic [31:0]         e_mag;
  logic [AccW-1:0]     e_mag_ext;
  logic [WIN_LOG2-1:0] cnt_q;
  logic [AccW-1:0]     acc_q;
  logic                pend_q;
  logic [31:0]         avg_q;
  logic                done_q;

  assign e_neg = -e_in;

  // Only -2^32 has no 32-bit magnitude; its negation lands on bit 32.
  always_comb begin
    e_mag = e_in[31:0];
    if (e_in[E_W-1]) begin
      e_mag = e_neg[E_W-1] ? 32'hFFFF_FFFF : e_neg[31:0];
    end
  end

  assign e_mag_ext = {{WIN_LOG2{1'b0}}, e_mag};

  // pend_q marks a full accumulator; the next edge publishes it and restarts the
  // window with whatever sample arrives on that same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      pend_q <= 1'b0;
      avg_q  <= '0;
      done_q <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= pend_q;
      if (pend_q) begin
        avg_q  <= 32'(acc_q >> WIN_LOG2);
        acc_q  <= e_valid ? e_mag_ext : '0;
        cnt_q  <= e_valid ? WIN_LOG2'(1) : '0;
        pend_q <= 1'b0;
      end else if (e_valid) begin
        acc_q <= acc_q + e_mag_ext;
        cnt_q <= cnt_q + WIN_LOG2'(1);
        if (cnt_q == '1) begin
          pend_q <= 1'b1;
        end
      end
    end
  end

  assign avg_out  = avg_q;
  assign win_done = done_q;

endmodule

// File: rtl/lms_mu_scheduler.sv
// Adaptive step-size controller for the LMS canceller: fast shift while acquiring,
// slow shift once the windowed mean |e| has been quiet long enough, and a hold mode.
// Build option: define LMS_MU_RAMP_EN to ramp mu_out from MU_FAST+1 up to MU_SLOW one
// step per window while tracking; otherwise TRACK jumps straight to MU_SLOW.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   enable     - low forces IDLE
//   freeze     - requests HOLD from ACQUIRE/TRACK
//   e_in       - signed FIR error, e_valid qualifies it
//   mu_out     - registered shift for the FIR mu_in
//   state_out  - IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3
//   locked     - high while in TRACK
//   avg_out    - mean |e| of the last completed window, win_done pulses on update
module lms_mu_scheduler
  import a2d_lms_pkg::*;
#(
  parameter int unsigned     WIN_LOG2     = 6,
  parameter int unsigned     LOCK_WINDOWS = 4,
  parameter logic [31:0]     TH_LOCK      = 32'd64,
  parameter logic [31:0]     TH_LOSS      = 32'd512,
  parameter logic [MU_W-1:0] MU_FAST      = 8'd4,
  parameter logic [MU_W-1:0] MU_SLOW      = 8'd10,
  parameter logic [MU_W-1:0] MU_HOLD      = 8'd40
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  freeze,
  input  logic signed [E_W-1:0] e_in,
  input  logic                  e_valid,
  output logic [MU_W-1:0]       mu_out,
  output logic [1:0]            state_out,
  output logic                  locked,
  output logic [31:0]           avg_out,
  output logic                  win_done
);

`ifdef LMS_MU_RAMP_EN
  localparam logic [MU_W-1:0] MuTrackEntry = MU_FAST + 8'd1;
`else
  localparam logic [MU_W-1:0] MuTrackEntry = MU_SLOW;
`endif

  state_e          state_q;
  logic [3:0]      quiet_q;
  logic [4:0]      quiet_inc;
  logic [MU_W-1:0] mu_q;
  logic            locked_q;
  logic            win_clear;

  assign win_clear = (state_q == StIdle) || (state_q == StHold);
  assign quiet_inc = {1'b0, quiet_q} + 5'd1;

  err_window_avg #(
    .WIN_LOG2(WIN_LOG2)
  ) u_win (
    .clk     (clk),
    .reset   (reset),
    .clear   (win_clear),
    .e_in    (e_in),
    .e_valid (e_valid),
    .avg_out (avg_out),
    .win_done(win_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      quiet_q  <= '0;
      mu_q     <= MU_HOLD;
      locked_q <= 1'b0;
    end else if (!enable) begin
      state_q  <= StIdle;
      quiet_q  <= '0;
      mu_q     <= MU_HOLD;
      locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if (!freeze) begin
            state_q <= StAcquire;
            quiet_q <= '0;
            mu_q    <= MU_FAST;
          end
        end
        StAcquire: begin
          if (freeze) begin
            state_q <= StHold;
            quiet_q <= '0;
            mu_q    <= MU_HOLD;
          end else if (win_done) begin
            if (avg_out < TH_LOCK) begin
              if (quiet_inc >= 5'(LOCK_WINDOWS)) begin
                state_q  <= StTrack;
                quiet_q  <= '0;
                mu_q     <= MuTrackEntry;
                locked_q <= 1'b1;
              end else begin
                quiet_q <= quiet_inc[3:0];
              end
            end else begin
              quiet_q <= '0;
            end
          end
        end
        StTrack: begin
          if (freeze) begin
            state_q  <= StHold;
            quiet_q  <= '0;
            mu_q     <= MU_HOLD;
            locked_q <= 1'b0;
          end else if (win_done) begin
            if (avg_out > TH_LOSS) begin
              state_q  <= StAcquire;
              quiet_q  <= '0;
              mu_q     <= MU_FAST;
              locked_q <= 1'b0;
            end
`ifdef LMS_MU_RAMP_EN
            else if (mu_q < MU_SLOW) begin
              mu_q <= mu_q + 8'd1;
            end
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mu_out    = mu_q;
  assign state_out = state_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_lms_mu_scheduler.sv
module tb_lms_mu_scheduler;
  logic               clk = 1'b0;
  logic               reset, enable, freeze, e_valid;
  logic signed [32:0] e_in;
  logic [7:0]         mu_out;
  logic [1:0]         state_out;
  logic               locked;
  logic [31:0]        avg_out;
  logic               win_done;

  int errors = 0;
  int checks = 0;

`ifdef LMS_MU_RAMP_EN
  localparam logic [7:0] MuEntry = 8'd5;
  localparam logic [7:0] MuStep1 = 8'd6;
  localparam logic [7:0] MuStep2 = 8'd7;
`else
  localparam logic [7:0] MuEntry = 8'd10;
  localparam logic [7:0] MuStep1 = 8'd10;
  localparam logic [7:0] MuStep2 = 8'd10;
`endif

  lms_mu_scheduler #(
    .WIN_LOG2    (2),
    .LOCK_WINDOWS(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .freeze   (freeze),
    .e_in     (e_in),
    .e_valid  (e_valid),
    .mu_out   (mu_out),
    .state_out(state_out),
    .locked   (locked),
    .avg_out  (avg_out),
    .win_done (win_done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of input, then sample just after the edge.
  task automatic cyc(input logic v, input logic signed [32:0] e);
    e_valid = v;
    e_in    = e;
    @(posedge clk);
    #1;
  endtask

  // Four samples, the win_done edge, then the edge where the FSM reacts.
  task automatic run_window(input logic signed [32:0] e);
    for (int i = 0; i < 4; i++) cyc(1'b1, e);
    cyc(1'b0, 33'sd0);
    cyc(1'b0, 33'sd0);
  endtask

  // Leaves the DUT in ACQUIRE with an empty window.
  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; freeze = 1'b0;
    cyc(1'b0, 33'sd0);
    cyc(1'b0, 33'sd0);
    reset = 1'b0;
    cyc(1'b0, 33'sd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; freeze = 1'b0;
    cyc(1'b0, 33'sd0);
    cyc(1'b0, 33'sd0);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state_out); end
    checks++; if (mu_out !== 8'd40) begin errors++; $display("FAIL reset_mu: got %0d expected 40", mu_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    checks++; if (avg_out !== 32'd0) begin errors++; $display("FAIL reset_avg: got %0d expected 0", avg_out); end
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL reset_win_done: got %0b expected 0", win_done); end
    reset = 1'b0; enable = 1'b1;
    cyc(1'b0, 33'sd0);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL idle_to_acq: got %0d expected 1", state_out); end
    checks++; if (mu_out !== 8'd4) begin errors++; $display("FAIL acq_mu: got %0d expected 4", mu_out); end
    run_window(33'sd100);
    checks++; if (avg_out !== 32'd100) begin errors++; $display("FAIL pre_reset_avg: got %0d expected 100", avg_out); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 33'sd5);
    reset = 1'b1;
    cyc(1'b0, 33'sd0);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL midwin_reset_state: got %0d expected 0", state_out); end
    checks++; if (mu_out !== 8'd40) begin errors++; $display("FAIL midwin_reset_mu: got %0d expected 40", mu_out); end
    checks++; if (avg_out !== 32'd0) begin errors++; $display("FAIL midwin_reset_avg: got %0d expected 0", avg_out); end
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL midwin_reset_wd: got %0b expected 0", win_done); end
    reset = 1'b0;
  endtask

  task automatic test_window_avg();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, -33'sd100);
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL avg_early_wd: got %0b expected 0", win_done); end
    cyc(1'b0, 33'sd0);
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL avg_wd: got %0b expected 1", win_done); end
    checks++; if (avg_out !== 32'd100) begin errors++; $display("FAIL avg_neg100: got %0d expected 100", avg_out); end
    cyc(1'b0, 33'sd0);
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL avg_wd_pulse: got %0b expected 0", win_done); end
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL avg_noisy_state: got %0d expected 1", state_out); end
    for (int i = 0; i < 4; i++) cyc(1'b1, 33'h1_0000_0000);
    cyc(1'b0, 33'sd0);
    checks++; if (avg_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL avg_sat: got %0h expected ffffffff", avg_out); end
    cyc(1'b0, 33'sd0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 33'sd8);
    cyc(1'b1, 33'sd16);
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL b2b_wd1: got %0b expected 1", win_done); end
    checks++; if (avg_out !== 32'd8) begin errors++; $display("FAIL b2b_avg1: got %0d expected 8", avg_out); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 33'sd16);
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL b2b_wd_gap: got %0b expected 0", win_done); end
    cyc(1'b0, 33'sd0);
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL b2b_wd2: got %0b expected 1", win_done); end
    checks++; if (avg_out !== 32'd16) begin errors++; $display("FAIL b2b_avg2: got %0d expected 16", avg_out); end
    cyc(1'b0, 33'sd0);
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL b2b_lock: got %0d expected 2", state_out); end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 33'sd10);
      if (i == 9) begin
        checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL lock_wd2: got %0b expected 1", win_done); end
        checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL lock_pre_state: got %0d expected 1", state_out); end
      end
      if (i == 10) begin
        checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL lock_state: got %0d expected 2", state_out); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %0b expected 1", locked); end
        checks++; if (mu_out !== MuEntry) begin errors++; $display("FAIL lock_mu_entry: got %0d expected %0d", mu_out, MuEntry); end
      end
    end
    cyc(1'b0, 33'sd0);
    cyc(1'b0, 33'sd0);
    checks++; if (mu_out !== MuStep1) begin errors++; $display("FAIL lock_mu_step1: got %0d expected %0d", mu_out, MuStep1); end
  endtask

  task automatic test_track_loss();
    run_window(33'sd512);
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL track_512_state: got %0d expected 2", state_out); end
    checks++; if (mu_out !== MuStep2) begin errors++; $display("FAIL track_512_mu: got %0d expected %0d", mu_out, MuStep2); end
    run_window(33'sd1000);
    checks++; if (avg_out !== 32'd1000) begin errors++; $display("FAIL loss_avg: got %0d expected 1000", avg_out); end
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL loss_state: got %0d expected 1", state_out); end
    checks++; if (mu_out !== 8'd4) begin errors++; $display("FAIL loss_mu: got %0d expected 4", mu_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked: got %0b expected 0", locked); end
  endtask

  task automatic test_quiet_boundary();
    do_reset();
    run_window(33'sd63);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL quiet_63a: got %0d expected 1", state_out); end
    run_window(33'sd64);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL quiet_64: got %0d expected 1", state_out); end
    run_window(33'sd63);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL quiet_cleared: got %0d expected 1", state_out); end
    run_window(33'sd63);
    checks++; if (state_out !== 2'd2) begin errors++; $display("FAIL quiet_lock: got %0d expected 2", state_out); end
  endtask

  task automatic test_freeze();
    do_reset();
    run_window(33'sd10);
    for (int i = 0; i < 4; i++) cyc(1'b1, 33'sd10);
    cyc(1'b0, 33'sd0);
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL frz_wd: got %0b expected 1", win_done); end
    freeze = 1'b1;
    cyc(1'b0, 33'sd0);
    checks++; if (state_out !== 2'd3) begin errors++; $display("FAIL frz_state: got %0d expected 3", state_out); end
    checks++; if (mu_out !== 8'd40) begin errors++; $display("FAIL frz_mu: got %0d expected 40", mu_out); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL frz_locked: got %0b expected 0", locked); end
    for (int i = 0; i < 3; i++) cyc(1'b1, 33'sd1000);
    checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL frz_hold_wd: got %0b expected 0", win_done); end
    freeze = 1'b0;
    cyc(1'b1, 33'sd1000);
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL frz_release: got %0d expected 1", state_out); end
    checks++; if (mu_out !== 8'd4) begin errors++; $display("FAIL frz_release_mu: got %0d expected 4", mu_out); end
    run_window(33'sd20);
    checks++; if (avg_out !== 32'd20) begin errors++; $display("FAIL frz_fresh_avg: got %0d expected 20", avg_out); end
    checks++; if (state_out !== 2'd1) begin errors++; $display("FAIL frz_quiet_cleared: got %0d expected 1", state_out); end
  endtask

  task automatic test_gappy();
    logic signed [32:0] gv [4];
    gv = '{-33'sd7, 33'sd9, -33'sd11, 33'sd13};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, gv[k]);
      checks++; if (win_done !== 1'b0) begin errors++; $display("FAIL gappy_wd_early%0d: got %0b expected 0", k, win_done); end
      if (k < 3) begin
        cyc(1'b0, 33'sd0);
        cyc(1'b0, 33'sd0);
      end
    end
    cyc(1'b0, 33'sd0);
    checks++; if (win_done !== 1'b1) begin errors++; $display("FAIL gappy_wd: got %0b expected 1", win_done); end
    checks++; if (avg_out !== 32'd10) begin errors++; $display("FAIL gappy_avg: got %0d expected 10", avg_out); end
    cyc(1'b0, 33'sd0);
  endtask

  task automatic test_enable();
    do_reset();
    run_window(33'sd10);
    enable = 1'b0;
    cyc(1'b0, 33'sd0);
    checks++; if (state_out !== 2'd0) begin errors++; $display("FAIL disable_state: got %0d expected 0", state_out); end
    checks++; if (mu_out !== 8'd40) begin errors++; $display("FAIL disable_mu: got %0d expected 40", mu_out); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; freeze = 1'b0; e_valid = 1'b0; e_in = '0;
    test_reset();
    test_window_avg();
    test_back_to_back();
    test_lock();
    test_track_loss();
    test_quiet_boundary();
    test_freeze();
    test_gappy();
    test_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
